// File: rtl/pb_debouncer_multi.sv
`default_nettype none
// ============================================================================
// Module   : pb_debouncer_multi
// Purpose  : Multi-channel push-button conditioner. Each raw button input is
//            optionally inverted, double-flop synchronised, and debounced on
//            both press and release. Each channel provides a debounced
//            level, press/release pulses and optional auto-repeat pulses.
//
// Ports    : clk                in  1     single clock, posedge
//            rst                in  1     synchronous active-high reset
//            PB                 in  N_CH  raw asynchronous button inputs
//            repeat_en          in  N_CH  per-channel auto-repeat enable
//            PB_pressed_status  out N_CH  debounced pressed level
//            PB_pressed_pulse   out N_CH  one-cycle pulse on accepted press
//            PB_released_pulse  out N_CH  one-cycle pulse on accepted release
//            PB_repeat_pulse    out N_CH  one-cycle auto-repeat pulse
//            any_pressed        out 1     OR of all pressed-status bits
//
// Revision : 1.0  initial multi-channel release
// ============================================================================
module pb_debouncer_multi #(
    parameter int N_CH         = 4,
    parameter int DELAY        = 10,
    parameter int REPEAT_DELAY = 500,
    parameter int REPEAT_RATE  = 100,
    parameter bit ACTIVE_LOW   = 1'b0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [N_CH-1:0] PB,
    input  logic [N_CH-1:0] repeat_en,
    output logic [N_CH-1:0] PB_pressed_status,
    output logic [N_CH-1:0] PB_pressed_pulse,
    output logic [N_CH-1:0] PB_released_pulse,
    output logic [N_CH-1:0] PB_repeat_pulse,
    output logic            any_pressed
);

    // Debounce timer width; never needs to hold more than DELAY-1.
    localparam int c_TW   = (DELAY > 1) ? $clog2(DELAY) : 1;
    // Repeat counter width; never needs to hold more than max(limit)-1.
    localparam int c_RMAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int c_RW   = $clog2(c_RMAX + 1);

    localparam logic [c_TW-1:0] c_T_LAST  = c_TW'(DELAY - 1);
    localparam logic [c_RW-1:0] c_R_FIRST = c_RW'(REPEAT_DELAY - 1);
    localparam logic [c_RW-1:0] c_R_NEXT  = c_RW'(REPEAT_RATE - 1);

    localparam logic [N_CH-1:0] c_POL = {N_CH{ACTIVE_LOW}};

    localparam logic [1:0] c_ST_IDLE      = 2'd0;
    localparam logic [1:0] c_ST_PRESS_CNT = 2'd1;
    localparam logic [1:0] c_ST_PRESSED   = 2'd2;
    localparam logic [1:0] c_ST_REL_CNT   = 2'd3;

    // ------------------------------------------------------------------------
    // Polarity normalisation and two-flop synchroniser. Resetting to 0 means
    // the synchroniser starts at the idle (released) level.
    // ------------------------------------------------------------------------
    logic [N_CH-1:0] r_sync1;
    logic [N_CH-1:0] r_sync2;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= PB ^ c_POL;
            r_sync2 <= r_sync1;
        end
    end

    // ------------------------------------------------------------------------
    // Per-channel debounce FSM, debounce timer and repeat counter.
    // ------------------------------------------------------------------------
    generate
        for (genvar i = 0; i < N_CH; i++) begin : g_ch
            logic [1:0]      r_state;
            logic [1:0]      w_state_nxt;
            logic [c_TW-1:0] r_t;
            logic [c_TW-1:0] w_t_nxt;
            logic [c_RW-1:0] r_r;
            logic [c_RW-1:0] w_r_nxt;
            logic            r_first;
            logic            w_first_nxt;
            logic            r_status;
            logic            w_status_nxt;
            logic            r_press_p;
            logic            w_press_p_nxt;
            logic            r_rel_p;
            logic            w_rel_p_nxt;
            logic            r_rep_p;
            logic            w_rep_p_nxt;
            logic            w_sync;
            logic            w_t_last;
            logic [c_RW-1:0] w_r_limit;

            assign w_sync    = r_sync2[i];
            assign w_t_last  = (r_t == c_T_LAST);
            // Limit switches only while r is 0, so r never overshoots it.
            assign w_r_limit = r_first ? c_R_FIRST : c_R_NEXT;

            // State register, counters and registered outputs.
            always_ff @(posedge clk) begin
                if (rst) begin
                    r_state   <= c_ST_IDLE;
                    r_t       <= '0;
                    r_r       <= '0;
                    r_first   <= 1'b1;
                    r_status  <= 1'b0;
                    r_press_p <= 1'b0;
                    r_rel_p   <= 1'b0;
                    r_rep_p   <= 1'b0;
                end else begin
                    r_state   <= w_state_nxt;
                    r_t       <= w_t_nxt;
                    r_r       <= w_r_nxt;
                    r_first   <= w_first_nxt;
                    r_status  <= w_status_nxt;
                    r_press_p <= w_press_p_nxt;
                    r_rel_p   <= w_rel_p_nxt;
                    r_rep_p   <= w_rep_p_nxt;
                end
            end

            // Next-state logic and debounce timer.
            always_comb begin
                w_state_nxt = r_state;
                w_t_nxt     = r_t;
                case (r_state)
                    c_ST_IDLE: begin
                        if (w_sync) begin
                            w_state_nxt = c_ST_PRESS_CNT;
                            w_t_nxt     = '0;
                        end
                    end
                    c_ST_PRESS_CNT: begin
                        if (!w_sync) begin
                            w_state_nxt = c_ST_IDLE;
                        end else if (w_t_last) begin
                            w_state_nxt = c_ST_PRESSED;
                        end else begin
                            w_t_nxt = r_t + c_TW'(1);
                        end
                    end
                    c_ST_PRESSED: begin
                        if (!w_sync) begin
                            w_state_nxt = c_ST_REL_CNT;
                            w_t_nxt     = '0;
                        end
                    end
                    c_ST_REL_CNT: begin
                        if (w_sync) begin
                            w_state_nxt = c_ST_PRESSED;
                        end else if (w_t_last) begin
                            w_state_nxt = c_ST_IDLE;
                        end else begin
                            w_t_nxt = r_t + c_TW'(1);
                        end
                    end
                    default: begin
                        w_state_nxt = c_ST_IDLE;
                        w_t_nxt     = '0;
                    end
                endcase
            end

            // Output, pulse and repeat-counter logic. The repeat counter runs
            // on every cycle spent in PRESSED (including the cycle that leaves
            // for REL_CNT) and is frozen while a release is being qualified,
            // so a rejected release simply delays the repeat schedule.
            always_comb begin
                w_r_nxt       = r_r;
                w_first_nxt   = r_first;
                w_status_nxt  = r_status;
                w_press_p_nxt = 1'b0;
                w_rel_p_nxt   = 1'b0;
                w_rep_p_nxt   = 1'b0;
                case (r_state)
                    c_ST_PRESS_CNT: begin
                        if (w_sync && w_t_last) begin
                            w_press_p_nxt = 1'b1;
                            w_status_nxt  = 1'b1;
                            w_r_nxt       = '0;
                            w_first_nxt   = 1'b1;
                        end
                    end
                    c_ST_PRESSED: begin
                        if (repeat_en[i]) begin
                            if (r_r == w_r_limit) begin
                                w_rep_p_nxt = 1'b1;
                                w_r_nxt     = '0;
                                w_first_nxt = 1'b0;
                            end else begin
                                w_r_nxt = r_r + c_RW'(1);
                            end
                        end else begin
                            // Disabled repeat restarts the full initial delay.
                            w_r_nxt     = '0;
                            w_first_nxt = 1'b1;
                        end
                    end
                    c_ST_REL_CNT: begin
                        if (!w_sync && w_t_last) begin
                            w_rel_p_nxt  = 1'b1;
                            w_status_nxt = 1'b0;
                        end
                    end
                    default: begin
                        w_r_nxt = r_r;
                    end
                endcase
            end

            assign PB_pressed_status[i] = r_status;
            assign PB_pressed_pulse[i]  = r_press_p;
            assign PB_released_pulse[i] = r_rel_p;
            assign PB_repeat_pulse[i]   = r_rep_p;
        end
    endgenerate

    assign any_pressed = |PB_pressed_status;

endmodule
`default_nettype wire

// File: tb/tb_pb_debouncer_multi.sv
`default_nettype none
// ============================================================================
// Module   : tb_pb_debouncer_multi
// Purpose  : Self-checking bench for pb_debouncer_multi. A run-length
//            reference model predicts every cycle's outputs into a queue; a
//            monitor pops and compares after each clock edge.
// Revision : 1.0  initial
// ============================================================================
module tb_pb_debouncer_multi;

    localparam int N_CH         = 4;
    localparam int DELAY        = 4;
    localparam int REPEAT_DELAY = 8;
    localparam int REPEAT_RATE  = 3;
    localparam bit ACTIVE_LOW   = 1'b1;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [N_CH-1:0] PB = {N_CH{ACTIVE_LOW}};
    logic [N_CH-1:0] repeat_en = '0;
    logic [N_CH-1:0] PB_pressed_status;
    logic [N_CH-1:0] PB_pressed_pulse;
    logic [N_CH-1:0] PB_released_pulse;
    logic [N_CH-1:0] PB_repeat_pulse;
    logic            any_pressed;

    always #5 clk = ~clk;

    pb_debouncer_multi #(
        .N_CH        (N_CH),
        .DELAY       (DELAY),
        .REPEAT_DELAY(REPEAT_DELAY),
        .REPEAT_RATE (REPEAT_RATE),
        .ACTIVE_LOW  (ACTIVE_LOW)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .PB               (PB),
        .repeat_en        (repeat_en),
        .PB_pressed_status(PB_pressed_status),
        .PB_pressed_pulse (PB_pressed_pulse),
        .PB_released_pulse(PB_released_pulse),
        .PB_repeat_pulse  (PB_repeat_pulse),
        .any_pressed      (any_pressed)
    );

    typedef struct packed {
        logic [N_CH-1:0] st;
        logic [N_CH-1:0] pp;
        logic [N_CH-1:0] rp;
        logic [N_CH-1:0] rep;
        logic            any;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    // Reference model state: synchroniser delay line, accepted level, length
    // of the current run of samples that disagree with it, and the number of
    // enabled held cycles since the last press/repeat event.
    bit m_s1[N_CH];
    bit m_s2[N_CH];
    bit m_acc[N_CH];
    int m_run[N_CH];
    int m_el[N_CH];
    bit m_first[N_CH];

    // Predicts the outputs produced by the next rising edge from the inputs
    // that will be sampled on it.
    task automatic model_step();
        exp_t e;
        bit   held;
        e = '0;
        for (int c = 0; c < N_CH; c++) begin
            if (rst) begin
                m_s1[c]    = 1'b0;
                m_s2[c]    = 1'b0;
                m_acc[c]   = 1'b0;
                m_run[c]   = 0;
                m_el[c]    = 0;
                m_first[c] = 1'b1;
            end else begin
                // Steadily held: accepted pressed and no release being qualified.
                held = m_acc[c] && (m_run[c] == 0);
                if (m_s2[c] != m_acc[c]) m_run[c]++;
                else m_run[c] = 0;
                // A new level is accepted after DELAY+1 consecutive samples.
                if (m_run[c] == DELAY + 1) begin
                    m_acc[c] = ~m_acc[c];
                    m_run[c] = 0;
                    if (m_acc[c]) begin
                        e.pp[c]    = 1'b1;
                        m_el[c]    = 0;
                        m_first[c] = 1'b1;
                    end else begin
                        e.rp[c] = 1'b1;
                    end
                end
                if (held) begin
                    if (repeat_en[c]) begin
                        m_el[c]++;
                        if (m_el[c] == (m_first[c] ? REPEAT_DELAY : REPEAT_RATE)) begin
                            e.rep[c]   = 1'b1;
                            m_el[c]    = 0;
                            m_first[c] = 1'b0;
                        end
                    end else begin
                        m_el[c]    = 0;
                        m_first[c] = 1'b1;
                    end
                end
                m_s2[c] = m_s1[c];
                m_s1[c] = PB[c] ^ ACTIVE_LOW;
            end
            e.st[c] = m_acc[c];
        end
        e.any = |e.st;
        exp_q.push_back(e);
    endtask

    task automatic chk(input string name, input logic [N_CH-1:0] got, input logic [N_CH-1:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            if (errors <= 30)
                $display("FAIL %s at %0t: got %b, expected %b", name, $time, got, want);
        end
    endtask

    // Monitor: compares DUT outputs against the predicted response.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("pressed_status", PB_pressed_status, e.st);
                chk("pressed_pulse", PB_pressed_pulse, e.pp);
                chk("released_pulse", PB_released_pulse, e.rp);
                chk("repeat_pulse", PB_repeat_pulse, e.rep);
                chk("any_pressed", {{(N_CH-1){1'b0}}, any_pressed}, {{(N_CH-1){1'b0}}, e.any});
            end
        end
    end

    // Drive one cycle of stimulus (logical pressed levels) and predict it.
    task automatic cycle(input logic [N_CH-1:0] lvl, input logic [N_CH-1:0] en, input logic r);
        @(negedge clk);
        PB        = lvl ^ {N_CH{ACTIVE_LOW}};
        repeat_en = en;
        rst       = r;
        model_step();
    endtask

    task automatic hold(input logic [N_CH-1:0] lvl, input logic [N_CH-1:0] en, input int n);
        for (int k = 0; k < n; k++) cycle(lvl, en, 1'b0);
    endtask

    initial begin
        logic [N_CH-1:0] lvl;
        logic [N_CH-1:0] en;
        int              seg[N_CH];

        // Reset
        for (int k = 0; k < 3; k++) cycle('0, '0, 1'b1);

        // Basic press / release on ch0
        hold(4'b0001, '0, 20);
        hold(4'b0000, '0, 15);

        // Bounce on ch1: 3 high / 3 low for 40 cycles, then hold and release
        for (int k = 0; k < 40; k++) cycle(((k / 3) % 2 == 0) ? 4'b0010 : 4'b0000, '0, 1'b0);
        hold(4'b0010, '0, 20);
        hold(4'b0000, '0, 15);

        // Auto-repeat on ch2, disabled mid-hold, then re-enabled
        hold(4'b0100, 4'b0100, 40);
        hold(4'b0100, 4'b0000, 5);
        hold(4'b0100, 4'b0100, 20);
        hold(4'b0000, 4'b0100, 15);

        // Release bounce on ch3 with repeat enabled
        hold(4'b1000, 4'b1000, 20);
        hold(4'b0000, 4'b1000, 2);
        hold(4'b1000, 4'b1000, 20);
        hold(4'b0000, 4'b1000, 15);

        // Simultaneous press on all channels, staggered release
        hold(4'b1111, '0, 20);
        hold(4'b1110, '0, 10);
        hold(4'b1100, '0, 10);
        hold(4'b1000, '0, 10);
        hold(4'b0000, '0, 15);

        // Reset while ch0 is held and pressed
        hold(4'b0001, 4'b0001, 20);
        cycle(4'b0001, 4'b0001, 1'b1);
        hold(4'b0001, 4'b0001, 20);
        hold(4'b0000, 4'b0001, 15);

        // Randomised bouncing, holds, repeat enables and occasional reset
        lvl = '0;
        en  = '0;
        for (int c = 0; c < N_CH; c++) seg[c] = 1;
        for (int k = 0; k < 4000; k++) begin
            for (int c = 0; c < N_CH; c++) begin
                seg[c]--;
                if (seg[c] <= 0) begin
                    lvl[c] = ~lvl[c];
                    seg[c] = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 4))
                                                          : int'($urandom_range(5, 40));
                end
                if ($urandom_range(0, 49) == 0) en[c] = ~en[c];
            end
            cycle(lvl, en, ($urandom_range(0, 599) == 0) ? 1'b1 : 1'b0);
        end

        @(posedge clk);
        #2;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d predictions left, expected 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/pb_debouncer_multi.md
# pb_debouncer_multi

Multi-channel, parametrised push-button conditioner and the successor of the single-channel press debouncer. Each of `N_CH` raw mechanical inputs is double-flop synchronised, then debounced on both press and release. Each channel produces a level, press/release pulses and optional auto-repeat pulses. The block sits between board buttons and the control/UI logic; all outputs are synchronous to `clk`.

## Interface
- `N_CH`, 4: number of independent button channels (≥1).
- `DELAY`, 10: consecutive stable cycles required to accept a press or a release (≥2).
- `REPEAT_DELAY`, 500: cycles held in PRESSED before the first `repeat_pulse` (≥1).
- `REPEAT_RATE`, 100: cycles between subsequent `repeat_pulse`s (≥1).
- `ACTIVE_LOW`, 0: 1 = raw button reads 0 when pressed; the input is inverted before synchronisation.

- `clk` in 1: single clock; all logic on posedge.
- `rst` in 1: synchronous, active-high reset.
- `PB` in N_CH: raw asynchronous button inputs.
- `repeat_en` in N_CH: per-channel auto-repeat enable; sampled every cycle.
- `PB_pressed_status` out N_CH: debounced level, 1 while the button is accepted as pressed.
- `PB_pressed_pulse` out N_CH: one-cycle pulse on an accepted press.
- `PB_released_pulse` out N_CH: one-cycle pulse on an accepted release.
- `PB_repeat_pulse` out N_CH: one-cycle auto-repeat pulse while held.
- `any_pressed` out 1: OR of all `PB_pressed_status` bits (combinational from registers).

## Operation
- Per channel: `lvl = PB[i] ^ ACTIVE_LOW`, then two flops give `sync[i]`. The flops reset to 0, which is the idle level.
- Per channel FSM states: IDLE, PRESS_CNT, PRESSED, REL_CNT. Each channel has its own debounce timer `t` and repeat counter `r`.
- Counter widths:
  - `t` is `$clog2(DELAY)` bits wide.
  - `r` is `$clog2(max(REPEAT_DELAY,REPEAT_RATE)+1)` bits wide.
  - Neither counter ever wraps: each is cleared before it can reach its limit.
- IDLE:
  - `sync=1` → PRESS_CNT, `t=0`.
- PRESS_CNT:
  - `sync=0` → IDLE (bounce rejected, no output).
  - `sync=1` and `t==DELAY-1` → PRESSED; on the same edge `PB_pressed_pulse<=1` and `PB_pressed_status<=1`, and `r<=0`.
  - Otherwise `t<=t+1`.
- PRESSED:
  - `sync=0` → REL_CNT, `t=0`.
  - If `repeat_en[i]`: `r` increments each cycle. When `r` reaches REPEAT_DELAY-1 (first pulse) or REPEAT_RATE-1 (subsequent pulses), `PB_repeat_pulse<=1` and `r<=0`. A per-channel `first` flag selects which limit applies; it is set on entry to PRESSED and cleared after the first repeat pulse.
  - If `repeat_en[i]=0`: `r<=0` and `first<=1` every cycle, so re-enabling restarts the full REPEAT_DELAY.
- REL_CNT:
  - `PB_pressed_status` stays 1 and `r` is held (no repeat pulses).
  - `sync=1` → PRESSED (release rejected); `r` and `first` resume unchanged and no pulse is generated.
  - `sync=0` and `t==DELAY-1` → IDLE; on the same edge `PB_released_pulse<=1` and `PB_pressed_status<=0`.
  - Otherwise `t<=t+1`.
- Pulses are registered and deassert on the next edge unless re-asserted. Re-assertion is impossible for press/release; for repeat it requires REPEAT_RATE=1.
- Channels are fully independent. Simultaneous events on different channels produce simultaneous pulses on their respective bits.
- `PB_pressed_pulse` and `PB_repeat_pulse` never coincide on one channel: the first repeat pulse is at least REPEAT_DELAY cycles after the press pulse.

## Timing
- Reset values: all outputs 0, all FSMs IDLE, `t`, `r` and the sync flops 0, `first` 1.
- Reset mid-operation, on the reset edge:
  - all channels return to IDLE;
  - all outputs drop to 0;
  - no `PB_released_pulse` is emitted.
  - A button held through reset is re-debounced after `rst` falls and produces a fresh `PB_pressed_pulse`.
- Press latency: with `lvl` stable at 1 from the edge E0 onward, `PB_pressed_pulse` is high during the cycle after edge E0+DELAY+2, for exactly one cycle.
- Release latency: symmetric to the press latency. `PB_pressed_status` falls on the same edge that raises `PB_released_pulse`.
- Repeat timing: the first `PB_repeat_pulse` follows the press pulse by REPEAT_DELAY cycles. Subsequent pulses are spaced REPEAT_RATE cycles apart, excluding any cycles spent in REL_CNT.
- A glitch shorter than DELAY cycles (after synchronisation) never changes `PB_pressed_status`.

## Test plan
- DELAY=4, ch0: `PB` 0→1 held → `PB_pressed_pulse[0]` high 1 cycle, 6 cycles after the first sampling edge, and `PB_pressed_status[0]` stays 1. `PB` →0 → `PB_released_pulse[0]` high 1 cycle after the same latency, and status falls with it.
- Bounce rejection: toggle ch1 with 3-cycle high/low pulses for 40 cycles, then hold high. Only one `PB_pressed_pulse[1]` occurs, after the hold; no release pulse; other channels stay 0.
- Auto-repeat: REPEAT_DELAY=8, REPEAT_RATE=3, `repeat_en[2]=1`, hold ch2 for 30 cycles after the press pulse → repeat pulses at +8, +11, +14, … cycles relative to the press pulse. Clearing `repeat_en` mid-hold stops them; re-setting it gives the next pulse 8 cycles later.
- Release bounce: while ch3 is PRESSED, drop `PB` for 2 cycles → no `PB_released_pulse`, status stays 1, and the repeat schedule shifts by the 2 held cycles (plus synchroniser skew).
- Simultaneous press on all channels with ACTIVE_LOW=1 (`PB` 1→0) → all `PB_pressed_pulse` bits assert on the same cycle; `any_pressed`=1 until the last channel is released.
- Assert `rst` for 1 cycle while ch0 is held and PRESSED → outputs 0 the next cycle with no release pulse, then a new press pulse DELAY+2 cycles after `rst` falls.
